acc_cpu_param: RTL

Parametrised successor to the team's 8-bit accumulator adding machine. Controller FSM and datapath merged into one block. Data width and address width are generic. Adds SUB, store, conditional jump, zero/carry flags and halt. Memory is reached through a shared single-port interface with a ready handshake, so wait-state memories are supported. Sits under the top-level CPU wrapper, directly against the program/data memory.

---
 rtl/acc_cpu_pkg.sv | 46 ++++
 rtl/acc_cpu_alu.sv | 32 +++
 rtl/acc_cpu_param.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: shared types and helpers for the parametrised accumulator CPU.
// Holds the opcode, FSM-state and ALU-select enums plus the instruction-field
// extraction helpers. Optional feature macro used by the design: ACC_CPU_IMM_EN.
package acc_cpu_pkg;

    localparam int OPC_W = 3;

    // Widest instruction word the field helpers accept.
    localparam int MAX_W = 64;

    typedef enum logic [OPC_W-1:0] {
        OP_HLT = 3'b000,
        OP_LDA = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_STA = 3'b100,
        OP_JMP = 3'b101,
        OP_JZ  = 3'b110,
        OP_EXT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC_RD = 3'd2,
        ST_EXEC_WR = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2
    } alu_op_e;

    // The opcode lives in the top OPC_W bits of a data_w-wide instruction.
    function automatic opcode_e opcode_of(input logic [MAX_W-1:0] word, input int data_w);
        return opcode_e'(word[data_w-1 -: OPC_W]);
    endfunction

    // The operand is the low addr_w bits, returned zero-extended.
    function automatic logic [MAX_W-1:0] operand_of(input logic [MAX_W-1:0] word, input int addr_w);
        return word & ((64'd1 << addr_w) - 64'd1);
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational accumulator ALU.
// ADD reports carry-out, SUB reports borrow (a < b), PASS forwards b.
// Zero is always computed on the produced result.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    // One extra bit holds the carry (ADD) or the borrow (SUB wraps negative).
    always_comb begin
        wide = {1'b0, b};
        case (op)
            ALU_ADD: wide = {1'b0, a} + {1'b0, b};
            ALU_SUB: wide = {1'b0, a} - {1'b0, b};
            default: wide = {1'b0, b};
        endcase
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        zero   = (wide[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/acc_cpu_param.sv
// acc_cpu_param: parametrised accumulator CPU, controller and datapath in one.
// Talks to a single-port memory with a ready handshake; strobe, address and
// store data come from registers and stay put until the access completes.
// Optional feature: define ACC_CPU_IMM_EN to turn opcode 111 into ADDI
// (zero-extended operand added to ACC in DECODE); otherwise 111 is a NOP.
module acc_cpu_param
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ir_out,
    output logic [1:0]        flags_out
);

    state_e            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] ir;
    logic              c_flag;
    logic              z_flag;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              halted_q;

    logic [MAX_W-1:0]  ir_wide;
    opcode_e           opcode;
    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_b;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    assign ir_wide = MAX_W'(ir);
    assign opcode  = opcode_of(ir_wide, DATA_W);
    assign operand = ir[ADDR_W-1:0];
    assign pc_next = pc + 1'b1;
    assign imm     = {{(DATA_W-ADDR_W){1'b0}}, operand};

    // ADDI adds the immediate during DECODE; memory ops use read data in EXEC_RD.
    always_comb begin
        alu_b  = mem_rdata;
        alu_op = ALU_PASS;
        if (state == ST_DECODE) begin
            alu_b = imm;
        end
        case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_EXT:  alu_op = ALU_ADD;
            default: alu_op = ALU_PASS;
        endcase
    end

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (acc),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Main FSM: every state transition also sets up the next bus access so the
    // strobe is already registered when the new state begins. The read strobe
    // resets high because the first cycle after reset is a fetch from 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_FETCH;
            pc       <= '0;
            acc      <= '0;
            ir       <= '0;
            c_flag   <= 1'b0;
            z_flag   <= 1'b0;
            rd_q     <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        rd_q  <= 1'b0;
                        state <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    pc <= pc_next;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            rd_q   <= 1'b1;
                            addr_q <= operand;
                            state  <= ST_EXEC_RD;
                        end
                        OP_STA: begin
                            wr_q    <= 1'b1;
                            addr_q  <= operand;
                            wdata_q <= acc;
                            state   <= ST_EXEC_WR;
                        end
                        OP_JMP: begin
                            pc     <= operand;
                            rd_q   <= 1'b1;
                            addr_q <= operand;
                            state  <= ST_FETCH;
                        end
                        OP_JZ: begin
                            if (z_flag) begin
                                pc     <= operand;
                                addr_q <= operand;
                            end else begin
                                addr_q <= pc_next;
                            end
                            rd_q  <= 1'b1;
                            state <= ST_FETCH;
                        end
                        OP_EXT: begin
`ifdef ACC_CPU_IMM_EN
                            acc    <= alu_result;
                            c_flag <= alu_carry;
                            z_flag <= alu_zero;
`endif
                            rd_q   <= 1'b1;
                            addr_q <= pc_next;
                            state  <= ST_FETCH;
                        end
                        OP_HLT: begin
                            halted_q <= 1'b1;
                            state    <= ST_HALT;
                        end
                    endcase
                end

                ST_EXEC_RD: begin
                    if (mem_ready) begin
                        acc    <= alu_result;
                        z_flag <= alu_zero;
                        if (opcode != OP_LDA) begin
                            c_flag <= alu_carry;
                        end
                        rd_q   <= 1'b1;
                        addr_q <= pc;
                        state  <= ST_FETCH;
                    end
                end

                ST_EXEC_WR: begin
                    if (mem_ready) begin
                        wr_q   <= 1'b0;
                        rd_q   <= 1'b1;
                        addr_q <= pc;
                        state  <= ST_FETCH;
                    end
                end

                ST_HALT: begin
                    halted_q <= 1'b1;
                end

                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    // The read strobe is masked by reset so it is low while reset is held.
    assign mem_rd    = rd_q & reset;
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign halted    = halted_q;
    assign acc_out   = acc;
    assign pc_out    = pc;
    assign ir_out    = ir;
    assign flags_out = {c_flag, z_flag};

endmodule
